// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths, array size and index helpers for the systolic array slice
package systolic_pkg;

    localparam int BITS_A_DEF     = 8;
    localparam int BITS_B_DEF     = 8;
    localparam int MEM_A_DEPTH    = 256;
    localparam int MEM_B_DEPTH    = 256;
    localparam int BITS_C_DEF     = 24;
    localparam int DIM_DEF        = 8;

    // Row index needs at least one bit even for the smallest array.
    function automatic int row_idx_w(input int dim);
        return (dim <= 2) ? 1 : $clog2(dim);
    endfunction

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - fixed-depth register delay for one result lane
module delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout_o         = din_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mem_c_deskew.sv
// rtl/mem_c_deskew.sv - realigns skewed systolic result lanes into one registered vector per row
module mem_c_deskew
    import systolic_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEF,
    parameter int DIM    = DIM_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic signed [BITS_C-1:0]    Cin  [DIM],
    output logic signed [BITS_C-1:0]    Cout [DIM],
    output logic                        vld,
    output logic [row_idx_w(DIM)-1:0]   row_idx,
    output logic                        done
);

    localparam int             RW       = row_idx_w(DIM);
    localparam logic [RW-1:0]  LAST_ROW = RW'(DIM - 1);

    logic [DIM-1:0]    lane_vld;
    logic [DIM-1:0]    vs_q;
    logic [BITS_C-1:0] lane_gated   [DIM];
    logic [BITS_C-1:0] lane_aligned [DIM];
    logic [BITS_C-1:0] cout_q       [DIM];
    logic [RW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic              done_q, done_d;

    // Lane r is valid in the cycle en-for-its-row has travelled r stages; the last stage is vld itself.
    assign lane_vld = {vs_q[DIM-2:0], en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= '0;
        end else begin
            vs_q <= lane_vld;
        end
    end

    genvar r;
    generate
        for (r = 0; r < DIM; r++) begin : g_lane
            assign lane_gated[r] = lane_vld[r] ? Cin[r] : '0;

            delay_line #(
                .WIDTH (BITS_C),
                .DEPTH (DIM - 1 - r)
            ) u_delay (
                .clk    (clk),
                .rst_n  (rst_n),
                .din_i  (lane_gated[r]),
                .dout_o (lane_aligned[r])
            );

            assign Cout[r] = cout_q[r];
        end
    endgenerate

    // Invalid rows enter as zeros, so the output register is zero whenever vld is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                cout_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                cout_q[i] <= lane_aligned[i];
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        row_d  = row_q;
        done_d = 1'b0;
        if (lane_vld[DIM-1]) begin
            row_d  = cnt_q;
            done_d = (cnt_q == LAST_ROW);
            cnt_d  = (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            row_q  <= row_d;
            done_q <= done_d;
        end
    end

    assign vld     = vs_q[DIM-1];
    assign row_idx = row_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_c_deskew.sv
// tb/tb_mem_c_deskew.sv - randomized and directed checks of mem_c_deskew against a row-level model
module tb_mem_c_deskew;

    localparam int DIM    = 8;
    localparam int BITS_C = 24;
    localparam int NCYC   = 540;
    localparam int NRUN   = 530;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     en;
    logic signed [BITS_C-1:0] Cin  [DIM];
    logic signed [BITS_C-1:0] Cout [DIM];
    logic                     vld;
    logic [2:0]               row_idx;
    logic                     done;

    always #5 clk = ~clk;

    mem_c_deskew #(
        .BITS_C (BITS_C),
        .DIM    (DIM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .Cin     (Cin),
        .Cout    (Cout),
        .vld     (vld),
        .row_idx (row_idx),
        .done    (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    bit                       plan_en  [NCYC];
    bit                       plan_rst [NCYC];
    logic signed [BITS_C-1:0] plan_cin [NCYC][DIM];
    bit                       en_hist  [NCYC];

    // A row issued at cycle k presents lane r on Cin during cycle k+r.
    task automatic post_row(input int k, input logic signed [BITS_C-1:0] vals [DIM]);
        plan_en[k] = 1'b1;
        for (int i = 0; i < DIM; i++) begin
            plan_cin[k+i][i] = vals[i];
        end
    endtask

    initial begin
        logic signed [BITS_C-1:0] vals [DIM];
        logic [31:0]              rnd;
        int                       k;
        int                       cnt;
        int                       exp_row;
        bit                       ev;
        bit                       edone;

        for (int n = 0; n < NCYC; n++) begin
            plan_en[n]  = 1'b0;
            plan_rst[n] = 1'b0;
            en_hist[n]  = 1'b0;
            for (int i = 0; i < DIM; i++) begin
                rnd = $urandom;
                plan_cin[n][i] = (n % 3 == 0 || (n >= 55 && n < 76)) ? 24'hABCDEF : rnd[23:0];
            end
        end

        for (int i = 0; i < DIM; i++) vals[i] = 24'(i + 1);
        post_row(2, vals);

        for (int i = 0; i < DIM; i++) vals[i] = 24'(100 + i);
        post_row(6, vals);
        plan_rst[10] = 1'b1;

        for (int row = 0; row < 9; row++) begin
            for (int i = 0; i < DIM; i++) vals[i] = 24'(16 * row + i);
            post_row(20 + row, vals);
        end

        for (int row = 0; row < 8; row++) begin
            for (int i = 0; i < DIM; i++) vals[i] = ((i + row) % 2 == 1) ? 24'h7FFFFF : 24'h800000;
            post_row(40 + row, vals);
        end

        for (int i = 0; i < DIM; i++) vals[i] = 24'h123400 + 24'(i);
        post_row(60, vals);
        post_row(62, vals);

        for (int c = 200; c <= 510; c++) begin
            if ($urandom % 2 == 0) begin
                for (int i = 0; i < DIM; i++) begin
                    rnd = $urandom;
                    vals[i] = rnd[23:0];
                end
                post_row(c, vals);
            end
        end
        plan_rst[350] = 1'b1;
        plan_en[350]  = 1'b0;

        rst_n = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < DIM; i++) Cin[i] = 24'hABCDEF;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_vld", 64'(vld), 0);
        check_val("reset_row_idx", 64'(row_idx), 0);
        check_val("reset_done", 64'(done), 0);
        for (int i = 0; i < DIM; i++) check_val($sformatf("reset_cout%0d", i), 64'(Cout[i]), 0);

        cnt     = 0;
        exp_row = 0;
        for (int n = 0; n < NRUN; n++) begin
            rst_n = !plan_rst[n];
            en    = plan_en[n];
            Cin   = plan_cin[n];
            @(posedge clk);
            #1;
            en_hist[n] = plan_en[n] && !plan_rst[n];
            if (plan_rst[n]) begin
                for (int j = 0; j <= n; j++) en_hist[j] = 1'b0;
                cnt     = 0;
                exp_row = 0;
            end
            k     = n - (DIM - 1);
            ev    = !plan_rst[n] && k >= 0 && en_hist[k >= 0 ? k : 0];
            edone = 1'b0;
            if (ev) begin
                exp_row = cnt;
                edone   = (cnt == DIM - 1);
                cnt     = (cnt + 1) % DIM;
            end
            check_val($sformatf("vld@%0d", n), 64'(vld), 64'(ev));
            check_val($sformatf("row_idx@%0d", n), 64'(row_idx), 64'(exp_row));
            check_val($sformatf("done@%0d", n), 64'(done), 64'(edone));
            for (int i = 0; i < DIM; i++) begin
                check_val($sformatf("cout%0d@%0d", i, n), 64'(Cout[i]),
                          ev ? 64'(plan_cin[k+i][i]) : 64'sd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_c_deskew.md
MEM_C_DESKEW -- requirements
Module: mem_c_deskew

Interface
REQ-001 Parameter BITS_C, default 24, signed width of each result lane.
REQ-002 Parameter DIM, default 8, number of lanes (array columns); legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  lane-0 result valid; lane r is valid exactly r cycles after en.
REQ-006 Cin  input  signed [BITS_C-1:0] x DIM  skewed result lanes from the systolic array.
REQ-007 Cout  output  signed [BITS_C-1:0] x DIM  aligned result vector, registered.
REQ-008 vld  output  1  Cout holds one complete aligned vector this cycle.
REQ-009 row_idx  output  $clog2(DIM)  index of the vector on Cout, counting 0..DIM-1.
REQ-010 done  output  1  one-cycle pulse coincident with the vector whose row_idx is DIM-1.

Function
REQ-011 The block shall keep a DIM-stage valid shift register: stage 0 loads en; stage r loads stage r-1 on every edge.
REQ-012 Lane r data shall be captured only when its lane valid (stage r) is high; otherwise it shall enter the pipeline as 0.
REQ-013 Lane r shall pass through DIM-1-r alignment stages plus one output register, so that all lanes of one vector reach Cout together.
REQ-014 For en sampled high at edge k, lane DIM-1 is sampled at edge k+DIM-1, and Cout/vld shall be valid in the cycle after edge k+DIM-1.
REQ-015 Total latency from the en sample edge to vld shall be DIM cycles.
REQ-016 The block shall accept en high on consecutive cycles at full rate, with no bubbles and no stalls.
REQ-017 Gaps in en shall appear as vld-low gaps of equal length at the output.
REQ-018 When vld is low, Cout shall be all zeros.
REQ-019 row_idx shall increment modulo DIM on each cycle vld is high, and hold otherwise.
REQ-020 done shall be high only when vld=1 and row_idx=DIM-1; after done the next vector shall carry row_idx 0.
REQ-021 Data path shall be pure transport with no arithmetic; the sign and full BITS_C width shall be preserved.
REQ-022 No backpressure exists; the consumer shall accept every vld cycle.

Reset
REQ-023 While rst_n is low, all valid stages, alignment registers, Cout, vld, row_idx and done shall be 0.
REQ-024 Reset asserted mid-vector shall discard all in-flight data; no partial vector shall ever assert vld afterwards.
REQ-025 The first en sampled after reset release shall be treated as lane-0 valid of row 0.

Structure
REQ-026 BITS_C and DIM defaults, and the row-index width function, shall live in the shared package systolic_pkg with the memA/memB parameters.
REQ-027 Per-lane delay shall use one sub-module, delay_line, parameterised by WIDTH and DEPTH and instantiated in a generate loop.
REQ-028 The lane with DEPTH=0 (lane DIM-1) shall degenerate to a wire.

Verification (DIM=8, BITS_C=24)
REQ-029 Single vector: en=1 for one cycle, Cin[r]=r+1 at its skewed cycle -> vld=1 exactly 8 cycles later, Cout={1..8}, row_idx=0, done=0.
REQ-030 Eight back-to-back vectors: Cin[r]=16*row+r -> eight consecutive vld cycles with correct values and row_idx 0..7, done only on the 8th; a ninth vector gets row_idx 0.
REQ-031 Signed extremes: lanes carry -8388608 and 8388607 alternately -> Cout reproduces them bit-exact.
REQ-032 Gated lanes: Cin driven with 0xABCDEF while the lane is not valid, en pattern 1,0,1 -> outputs are zero in the gap, vld pattern 1,0,1.
REQ-033 Reset mid-operation: rst_n low for 1 cycle, 4 cycles after en -> no vld for that vector, all outputs 0, next vector row_idx=0.
REQ-034 Idle: en=0 for 100 cycles with random Cin -> vld=0, Cout=0 and done=0 throughout.
